buffer_write_arbiter: RTL



---
 rtl/buffer_write_arbiter_if.sv | 35 +++
 rtl/buffer_write_arbiter.sv | 91 +++++++++
 2 files changed

// File: rtl/buffer_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : buffer_write_arbiter_if
// Brief    : Requester/buffer-side bundle for the buffer write arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface buffer_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4
);
  localparam int c_CW = $clog2(DEPTH + 1);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      free_in;
  logic [NUM_REQ-1:0]        gnt;
  logic                      buf_write_en;
  logic [DATA_W-1:0]         buf_data;
  logic [c_CW-1:0]           credits;
  logic                      full;
  logic                      overflow_err;

  // Requesters and consumer drive the request/credit-return side.
  modport master (
    output req, req_data, free_in,
    input  gnt, buf_write_en, buf_data, credits, full, overflow_err
  );

  modport slave (
    input  req, req_data, free_in,
    output gnt, buf_write_en, buf_data, credits, full, overflow_err
  );
endinterface
`default_nettype wire

// File: rtl/buffer_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : buffer_write_arbiter
// Brief    : Round-robin, credit-guarded arbiter for a shared buffer write port.
// Revision : 1.0  initial release
// ============================================================================
module buffer_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4
) (
  input  wire                     clk,
  input  wire                     rst_n,
  buffer_write_arbiter_if.slave   bus
);
  localparam int c_PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int c_CW = $clog2(DEPTH + 1);
  localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);

  logic [NUM_REQ-1:0] r_gnt;
  logic               r_write_en;
  logic [DATA_W-1:0]  r_data;
  logic [c_CW-1:0]    r_credits;
  logic               r_overflow;
  logic [c_PW-1:0]    r_rr_ptr;

  logic [NUM_REQ-1:0] w_req_eff;
  logic               w_found;
  logic [c_PW-1:0]    w_idx;
  logic               w_grant;
  logic               w_free_ok;
  logic [DATA_W-1:0]  w_sel_data;

  function automatic logic [c_PW-1:0] wrap_add(input logic [c_PW-1:0] base,
                                               input int unsigned      off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return c_PW'(s);
  endfunction

  // A requester is masked in the cycle it is granted so it may drop req then.
  assign w_req_eff = bus.req & ~r_gnt;

  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && w_req_eff[wrap_add(r_rr_ptr, k)]) begin
        w_found = 1'b1;
        w_idx   = wrap_add(r_rr_ptr, k);
      end
    end
  end

  // Eligibility always uses the pre-update credit count.
  assign w_grant    = w_found && (r_credits != '0);
  assign w_free_ok  = bus.free_in && (r_credits != c_DEPTH);
  assign w_sel_data = bus.req_data[w_idx*DATA_W +: DATA_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gnt      <= '0;
      r_write_en <= 1'b0;
      r_data     <= '0;
      r_credits  <= c_DEPTH;
      r_overflow <= 1'b0;
      r_rr_ptr   <= '0;
    end else begin
      r_credits <= r_credits - c_CW'(w_grant) + c_CW'(w_free_ok);
      if (bus.free_in && (r_credits == c_DEPTH)) r_overflow <= 1'b1;
      if (w_grant) begin
        r_gnt      <= NUM_REQ'(1) << w_idx;
        r_write_en <= 1'b1;
        r_data     <= w_sel_data;
        r_rr_ptr   <= wrap_add(w_idx, 1);
      end else begin
        r_gnt      <= '0;
        r_write_en <= 1'b0;
      end
    end
  end

  assign bus.gnt          = r_gnt;
  assign bus.buf_write_en = r_write_en;
  assign bus.buf_data     = r_data;
  assign bus.credits      = r_credits;
  assign bus.full         = (r_credits == '0);
  assign bus.overflow_err = r_overflow;
endmodule
`default_nettype wire
